// File: rtl/turbo_pb_buf.sv
// Ping-pong soft-bit buffer: captures one PB per bank at write index `enable`, streams it out in index order.
// Read latency 1-cycle RAM + 2-entry skid (dout_vld 3 edges after completing write); dout holds while !dout_rdy.
module turbo_pb_buf #(
  parameter int SW    = 6,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          din_vld,
  input  logic [SW-1:0] din,
  input  logic          wen,
  input  logic [11:0]   enable,
  input  logic [11:0]   pb_len,
  input  logic          dout_rdy,
  output logic [SW-1:0] dout,
  output logic          dout_vld,
  output logic [11:0]   dout_idx,
  output logic          dout_last,
  output logic          full,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  typedef struct packed {
    logic [SW-1:0] dat;
    logic [11:0]   idx;
    logic          last;
  } ent_t;

  logic [SW-1:0] mem [2][DEPTH];
  logic [1:0]    bank_full;
  logic [11:0]   bank_len [2];
  logic          wb, rb;
  logic [11:0]   wr_cnt, len_lat, len_cur;
  logic          wr_hit, wr_acc, wr_done;

  state_t        state, state_nxt;
  logic [11:0]   rd_idx, rd_len;
  logic          issue, pop;
  logic          pend, pend_last;
  logic [11:0]   pend_idx;
  logic [SW-1:0] rd_dat;
  ent_t          ent0, ent1, ent_new;
  logic [1:0]    cnt;

  // First write of a frame takes its length straight from pb_len.
  assign len_cur = (wr_cnt == 12'd0) ? pb_len : len_lat;
  assign wr_hit  = wen & din_vld;
  assign wr_acc  = wr_hit & ~bank_full[wb] & (enable < len_cur);
  assign wr_done = wr_acc & (wr_cnt == len_cur - 12'd1);

  assign rd_len  = bank_len[rb];
  assign pop     = dout_vld & dout_rdy;
  assign ent_new = {rd_dat, pend_idx, pend_last};

  assign dout      = ent0.dat;
  assign dout_idx  = ent0.idx;
  assign dout_last = ent0.last;
  assign dout_vld  = (cnt != 2'd0);
  assign full      = bank_full[0] & bank_full[1];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wb][enable] <= din;
    if (issue)  rd_dat <= mem[rb][rd_idx];
  end

  always_ff @(posedge clk) begin
    if (n_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Issue only while the skid plus the in-flight read still has a free slot after this cycle's pop.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:   if (bank_full[rb]) state_nxt = STREAM;
      STREAM: begin
        issue = (rd_idx < rd_len) &&
                (({1'b0, cnt} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));
        if (pop && ent0.last) state_nxt = DONE;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      bank_full   <= 2'b00;
      bank_len[0] <= 12'd0;
      bank_len[1] <= 12'd0;
      wb          <= 1'b0;
      rb          <= 1'b0;
      wr_cnt      <= 12'd0;
      len_lat     <= 12'd0;
      err         <= 1'b0;
      rd_idx      <= 12'd0;
      pend        <= 1'b0;
      pend_idx    <= 12'd0;
      pend_last   <= 1'b0;
      cnt         <= 2'd0;
      ent0        <= '0;
      ent1        <= '0;
    end else begin
      err <= wr_hit & ~wr_acc;
      if (wr_acc) begin
        if (wr_cnt == 12'd0) len_lat <= pb_len;
        wr_cnt <= wr_done ? 12'd0 : wr_cnt + 12'd1;
        if (wr_done) begin
          bank_full[wb] <= 1'b1;
          bank_len[wb]  <= len_cur;
          wb            <= ~wb;
        end
      end
      // The set above targets a non-full bank, so it never collides with this clear.
      if (state == DONE) begin
        bank_full[rb] <= 1'b0;
        rb            <= ~rb;
      end

      if (state == IDLE) rd_idx <= 12'd0;
      else if (issue)    rd_idx <= rd_idx + 12'd1;
      pend <= issue;
      if (issue) begin
        pend_idx  <= rd_idx;
        pend_last <= (rd_idx == rd_len - 12'd1);
      end

      case ({pend, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= ent_new;
          else             ent1 <= ent_new;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) ent0 <= ent_new;
          else begin
            ent0 <= ent1;
            ent1 <= ent_new;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_turbo_pb_buf.sv
// Directed bench for turbo_pb_buf: vector table for the write-side accept/drop rules plus frame-level sequences.
module tb_turbo_pb_buf;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        din_vld;
  logic [5:0]  din;
  logic        wen;
  logic [11:0] enable;
  logic [11:0] pb_len;
  logic        dout_rdy;
  logic [5:0]  dout;
  logic        dout_vld;
  logic [11:0] dout_idx;
  logic        dout_last;
  logic        full;
  logic        err;

  turbo_pb_buf #(.SW(6), .DEPTH(4096)) dut (
    .clk(clk), .n_rst(n_rst), .din_vld(din_vld), .din(din), .wen(wen),
    .enable(enable), .pb_len(pb_len), .dout_rdy(dout_rdy), .dout(dout),
    .dout_vld(dout_vld), .dout_idx(dout_idx), .dout_last(dout_last),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic        wen;
    logic        vld;
    logic [11:0] en;
    logic [11:0] len;
    logic [5:0]  d;
    logic        e_err;
    logic        e_full;
    logic        e_vld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] dval(input int base, input int mul, input int i);
    int v;
    v = (base + i * mul) & 63;
    return v[5:0];
  endfunction

  task automatic write_pb(input int n, input int base, input int mul, input bit rev, input bit drop);
    for (int i = 0; i < n; i++) begin
      int e;
      e = rev ? (n - 1 - i) : i;
      wen = 1'b1; din_vld = 1'b1;
      enable = e[11:0]; pb_len = n[11:0];
      din = dval(base, mul, e);
      tick();
      if (drop) chk("drop_err", err, 1);
    end
    wen = 1'b0; din_vld = 1'b0;
    if (!drop)
      for (int i = 0; i < n; i++) exp_q.push_back(dval(base, mul, i));
  endtask

  task automatic drain(input int n, input bit rnd);
    int got;
    int cyc;
    bit stalled;
    logic [18:0] held;
    logic [5:0] e;
    got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < n && cyc < 8 * n + 40) begin
      if (stalled) chk("stall_hold", {dout_vld, dout, dout_idx, dout_last}, {1'b1, held});
      dout_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin
          e = 6'h0;
          chk("exp_underflow", 1, 0);
        end
        chk("out_entry", {dout, dout_idx, dout_last},
            {e, got[11:0], (got == n - 1) ? 1'b1 : 1'b0});
        got++;
      end
      stalled = dout_vld && !dout_rdy;
      held    = {dout, dout_idx, dout_last};
      tick();
      cyc++;
    end
    dout_rdy = 1'b0;
    chk("hs_count", got, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[11];
    bit hit;
    int c;
    int got;
    logic [5:0] e;

    n_rst = 1'b1; din_vld = 1'b0; din = '0; wen = 1'b0;
    enable = '0; pb_len = '0; dout_rdy = 1'b0;
    tick(); tick();
    chk("rst_outs", {dout_vld, dout, dout_idx, dout_last, full, err}, 0);
    n_rst = 1'b0;
    tick();
    chk("rst_idle", {dout_vld, full, err}, 0);

    // 16 sequential entries, din = index; dout_vld three edges after the last write
    write_pb(16, 0, 1, 1'b0, 1'b0);
    chk("lat_k",  dout_vld, 0);
    tick(); chk("lat_k1", dout_vld, 0);
    tick(); chk("lat_k2", dout_vld, 0);
    tick(); chk("lat_k3", dout_vld, 1);
    chk("first_out", {dout, dout_idx, dout_last}, {6'd0, 12'd0, 1'b0});
    drain(16, 1'b0);

    // reverse-order write indices, output still in index order
    write_pb(16, 5, 7, 1'b1, 1'b0);
    drain(16, 1'b0);

    // three 136-entry PBs with consumer stalled: third is dropped entirely
    write_pb(136, 1, 3, 1'b0, 1'b0);
    chk("full_pb1", full, 0);
    write_pb(136, 40, 5, 1'b0, 1'b0);
    chk("full_pb2", full, 1);
    write_pb(136, 17, 11, 1'b0, 1'b1);
    chk("full_pb3", full, 1);
    tick();
    chk("err_clear", err, 0);
    drain(136, 1'b0);
    drain(136, 1'b0);
    tick(); tick();
    chk("empty_after", {full, dout_vld}, 0);

    // 520 entries with random consumer backpressure
    write_pb(520, 9, 13, 1'b0, 1'b0);
    drain(520, 1'b1);

    // reset while streaming entry 70 of 136
    write_pb(136, 3, 9, 1'b0, 1'b0);
    dout_rdy = 1'b1;
    hit = 1'b0; c = 0; got = 0;
    while (!hit && c < 400) begin
      if (dout_vld) begin
        e = (exp_q.size() > 0) ? exp_q[0] : 6'h0;
        if (exp_q.size() > 0) exp_q.delete(0);
        chk("pre_rst_out", {dout, dout_idx}, {e, got[11:0]});
        got++;
        if (dout_idx == 12'd70) begin
          hit = 1'b1;
          n_rst = 1'b1;
        end
      end
      tick();
      c++;
    end
    chk("reach_idx70", hit, 1);
    chk("midrst_outs", {dout_vld, full, err}, 0);
    n_rst = 1'b0; dout_rdy = 1'b0;
    exp_q.delete();
    tick();
    chk("midrst_quiet", dout_vld, 0);
    write_pb(16, 21, 5, 1'b0, 1'b0);
    drain(16, 1'b1);

    // write-side accept/drop vectors (banks empty, wr_cnt = 0 here)
    tv[0]  = '{1'b1, 1'b1, 12'd20, 12'd16, 6'h00, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 12'd0,  12'd0,  6'h00, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 12'd0,  12'd2,  6'h00, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 12'd0,  12'd2,  6'h00, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 12'd1,  12'd2,  6'h11, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 12'd5,  12'd16, 6'h00, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 12'd0,  12'd16, 6'h22, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 12'd0,  12'd3,  6'h33, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 12'd2,  12'd9,  6'h2c, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 12'd1,  12'd9,  6'h15, 1'b0, 1'b1, 1'b1};
    tv[10] = '{1'b1, 1'b1, 12'd0,  12'd4,  6'h00, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      wen = tv[i].wen; din_vld = tv[i].vld;
      enable = tv[i].en; pb_len = tv[i].len; din = tv[i].d;
      tick();
      chk($sformatf("vec%0d_err", i), err, tv[i].e_err);
      chk($sformatf("vec%0d_full_vld", i), {full, dout_vld}, {tv[i].e_full, tv[i].e_vld});
    end
    wen = 1'b0; din_vld = 1'b0;
    exp_q.push_back(6'h22); exp_q.push_back(6'h11);
    exp_q.push_back(6'h33); exp_q.push_back(6'h15); exp_q.push_back(6'h2c);
    drain(2, 1'b0);
    drain(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
